// File: rtl/fc_pkg.sv
// Shared definitions for the two-layer fully connected network: default word and
// address widths, class count, and the argmax readout state encoding.
package fc_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 8;
    localparam int NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } argmax_state_t;

endpackage

// File: rtl/argmax_readout_if.sv
// Read port of the layer-2 result RAM as seen by the argmax readout stage.
interface argmax_readout_if #(
    parameter int DATA_W = fc_pkg::DATA_W,
    parameter int ADDR_W = fc_pkg::ADDR_W
);
    // No ready: rd_en with rd_addr is an unconditional read request, and rd_data
    // belongs to that request exactly one cycle later (fixed-latency synchronous RAM).
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/argmax_readout.sv
// Scans NUM_CLASSES signed scores from the layer-2 result RAM and reports the
// index and value of the largest one (lowest index on ties) with a done pulse.
module argmax_readout #(
    parameter int NUM_CLASSES = fc_pkg::NUM_CLASSES,
    parameter int DATA_W      = fc_pkg::DATA_W,
    parameter int ADDR_W      = fc_pkg::ADDR_W,
    parameter int BASE_ADDR   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     class_idx,
    output logic [DATA_W-1:0]     max_val,
    output fc_pkg::argmax_state_t dbg_state,
    argmax_readout_if.master      ram
);
    import fc_pkg::*;

    // One extra counter bit so a full 2^ADDR_W scan terminates without wrapping.
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_CLASSES - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    argmax_state_t     state_q, state_d;

    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic              busy_q;
    logic              last_issue;
    logic              accept;

    logic              rd_valid_q;
    logic [CNT_W-1:0]  rcv_cnt_q;
    logic              run_valid_q;
    logic [DATA_W-1:0] run_max_q;
    logic [ADDR_W-1:0] run_idx_q;
    logic              take_word;
    logic [DATA_W-1:0] run_max_d;
    logic [ADDR_W-1:0] run_idx_d;

    logic              done_q;
    logic [ADDR_W-1:0] class_idx_q;
    logic [DATA_W-1:0] max_val_q;

    assign last_issue = (issue_cnt_q == LAST_IDX);
    assign accept     = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (last_issue) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address issue side: one read per cycle while in READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= BASE;
                        issue_cnt_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                READ: begin
                    if (last_issue) begin
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_addr_q   <= rd_addr_q + 1'b1;
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                end
                DONE:    busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // A strictly-greater signed compare keeps the earliest index on ties.
    always_comb begin
        take_word = rd_valid_q &&
                    (!run_valid_q || ($signed(ram.rd_data) > $signed(run_max_q)));
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        if (take_word) begin
            run_max_d = ram.rd_data;
            run_idx_d = rcv_cnt_q[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rcv_cnt_q   <= '0;
            run_valid_q <= 1'b0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            done_q      <= 1'b0;
            class_idx_q <= '0;
            max_val_q   <= '0;
        end else begin
            rd_valid_q <= rd_en_q;
            if (accept) begin
                rcv_cnt_q   <= '0;
                run_valid_q <= 1'b0;
            end else if (rd_valid_q) begin
                rcv_cnt_q   <= rcv_cnt_q + 1'b1;
                run_valid_q <= 1'b1;
                run_max_q   <= run_max_d;
                run_idx_q   <= run_idx_d;
            end
            // The last word arrives during DRAIN, so publish the post-update values.
            done_q <= (state_q == DRAIN);
            if (state_q == DRAIN) begin
                class_idx_q <= run_idx_d;
                max_val_q   <= run_max_d;
            end
        end
    end

    assign ram.rd_en   = rd_en_q;
    assign ram.rd_addr = rd_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_idx   = class_idx_q;
    assign max_val     = max_val_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_argmax_readout.sv
// Directed bench for argmax_readout: a 10-class instance at base 0 and a
// single-class instance at base 0x40, each reading from a behavioural RAM.
module tb_argmax_readout;
  import fc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NA = 10;
  localparam int NB = 1;
  localparam int BASE_B = 'h40;
  localparam int W = AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic busy_a, done_a, busy_b, done_b;
  logic [AW-1:0] class_idx_a, class_idx_b;
  logic [DW-1:0] max_val_a, max_val_b;
  argmax_state_t state_a, state_b;

  argmax_readout_if #(.DATA_W(DW), .ADDR_W(AW)) ram_a ();
  argmax_readout_if #(.DATA_W(DW), .ADDR_W(AW)) ram_b ();

  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int exp_done_a = 0;
  logic [AW-1:0] held_idx = '0;
  logic [DW-1:0] held_val = '0;

  int s_mixed [NA] = '{3, -7, 12, 0, 5, 12, -1, 8, 2, 4};
  int s_neg   [NA] = '{-5, -3, -32768, -3, -9, -100, -20, -32768, -7, -4};

  always #5 clk = ~clk;

  argmax_readout #(.NUM_CLASSES(NA), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .class_idx(class_idx_a), .max_val(max_val_a), .dbg_state(state_a), .ram(ram_a)
  );

  argmax_readout #(.NUM_CLASSES(NB), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .class_idx(class_idx_b), .max_val(max_val_b), .dbg_state(state_b), .ram(ram_b)
  );

  always @(posedge clk) if (ram_a.rd_en) ram_a.rd_data <= mem_a[ram_a.rd_addr];
  always @(posedge clk) if (ram_b.rd_en) ram_b.rd_data <= mem_b[ram_b.rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference argmax over mem_a[0..NA-1]: first occurrence of the largest signed value.
  function automatic logic [W-1:0] ref_argmax();
    int bi = 0;
    for (int i = 1; i < NA; i++)
      if ($signed(mem_a[i]) > $signed(mem_a[bi])) bi = i;
    return {AW'(bi), mem_a[bi]};
  endfunction

  task automatic load_rand(input int lo, input int hi);
    for (int i = 0; i < NA; i++) mem_a[i] = DW'(int'($urandom_range(hi - lo)) + lo);
  endtask

  always @(negedge clk) begin : mon_a
    logic [W-1:0] e;
    if (done_a === 1'b1) begin
      done_cnt_a++;
      chk("a_sb_pending", 32'(exp_q_a.size() != 0), 32'd1);
      if (exp_q_a.size() != 0) begin
        e = exp_q_a.pop_front();
        chk("a_done_class_idx", 32'(class_idx_a), 32'(e[W-1:DW]));
        chk("a_done_max_val", 32'(max_val_a), 32'(e[DW-1:0]));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [W-1:0] e;
    if (done_b === 1'b1) begin
      done_cnt_b++;
      chk("b_sb_pending", 32'(exp_q_b.size() != 0), 32'd1);
      if (exp_q_b.size() != 0) begin
        e = exp_q_b.pop_front();
        chk("b_done_class_idx", 32'(class_idx_b), 32'(e[W-1:DW]));
        chk("b_done_max_val", 32'(max_val_b), 32'(e[DW-1:0]));
      end
    end
  end

  // Start in the current cycle (cycle 0) and walk cycles 1..NA+3 against the timing
  // contract; p1/p2 are cycles in which an extra start pulse is driven (0 = none).
  task automatic scan_a(input string tag, input logic [W-1:0] exp, input int p1, input int p2);
    exp_q_a.push_back(exp);
    exp_done_a++;
    start_a = 1'b1;
    for (int c = 1; c <= NA + 3; c++) begin
      tick();
      start_a = (c == p1) || (c == p2);
      chk($sformatf("%s_rd_en_c%0d", tag, c), 32'(ram_a.rd_en), 32'(c <= NA));
      if (c <= NA) chk($sformatf("%s_rd_addr_c%0d", tag, c), 32'(ram_a.rd_addr), 32'(c - 1));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy_a), 32'(c <= NA + 2));
      chk($sformatf("%s_done_c%0d", tag, c), 32'(done_a), 32'(c == NA + 2));
      if (c <= NA + 1) begin
        chk($sformatf("%s_held_idx_c%0d", tag, c), 32'(class_idx_a), 32'(held_idx));
        chk($sformatf("%s_held_val_c%0d", tag, c), 32'(max_val_a), 32'(held_val));
      end else begin
        chk($sformatf("%s_res_idx_c%0d", tag, c), 32'(class_idx_a), 32'(exp[W-1:DW]));
        chk($sformatf("%s_res_val_c%0d", tag, c), 32'(max_val_a), 32'(exp[DW-1:0]));
      end
    end
    start_a = 1'b0;
    chk({tag, "_state_idle"}, 32'(state_a), 32'(IDLE));
    held_idx = exp[W-1:DW];
    held_val = exp[DW-1:0];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_a_done"}, 32'(done_a), 32'd0);
    chk({tag, "_a_rd_en"}, 32'(ram_a.rd_en), 32'd0);
    chk({tag, "_a_rd_addr"}, 32'(ram_a.rd_addr), 32'd0);
    chk({tag, "_a_class_idx"}, 32'(class_idx_a), 32'd0);
    chk({tag, "_a_max_val"}, 32'(max_val_a), 32'd0);
    chk({tag, "_a_state"}, 32'(state_a), 32'(IDLE));
    chk({tag, "_b_busy"}, 32'(busy_b), 32'd0);
    chk({tag, "_b_rd_en"}, 32'(ram_b.rd_en), 32'd0);
    chk({tag, "_b_rd_addr"}, 32'(ram_b.rd_addr), 32'd0);
    chk({tag, "_b_class_idx"}, 32'(class_idx_b), 32'd0);
    chk({tag, "_b_max_val"}, 32'(max_val_b), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Mixed scores with a tie between index 2 and 5
    for (int i = 0; i < NA; i++) mem_a[i] = DW'(s_mixed[i]);
    scan_a("mixed", {8'd2, 16'd12}, 0, 0);

    // All negative, including the most negative code
    for (int i = 0; i < NA; i++) mem_a[i] = DW'(s_neg[i]);
    scan_a("neg", {8'd1, 16'hFFFD}, 0, 0);

    // Single-class instance at base 0x40
    mem_b[BASE_B] = 16'h7FFF;
    mem_b[BASE_B + 1] = 16'h8000;
    exp_q_b.push_back({8'd0, 16'h7FFF});
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("one_c1_rd_en", 32'(ram_b.rd_en), 32'd1);
    chk("one_c1_rd_addr", 32'(ram_b.rd_addr), 32'(BASE_B));
    chk("one_c1_busy", 32'(busy_b), 32'd1);
    tick();
    chk("one_c2_rd_en", 32'(ram_b.rd_en), 32'd0);
    chk("one_c2_done", 32'(done_b), 32'd0);
    chk("one_c2_state", 32'(state_b), 32'(DRAIN));
    tick();
    chk("one_c3_done", 32'(done_b), 32'd1);
    chk("one_c3_busy", 32'(busy_b), 32'd1);
    tick();
    chk("one_c4_busy", 32'(busy_b), 32'd0);
    chk("one_c4_done", 32'(done_b), 32'd0);
    chk("one_c4_max_held", 32'(max_val_b), 32'h7FFF);

    // Extra start pulses mid-scan and in the DONE cycle are ignored
    load_rand(-30000, 30000);
    scan_a("restart", ref_argmax(), 4, NA + 2);

    // Reset asserted in cycle 5 of a scan aborts it without a done pulse
    load_rand(-500, 500);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("abort");
    held_idx = '0;
    held_val = '0;
    for (int c = 0; c < NA + 4; c++) begin
      tick();
      chk($sformatf("abort_quiet_done_%0d", c), 32'(done_a), 32'd0);
    end
    scan_a("after_abort", ref_argmax(), 0, 0);

    // Back-to-back scans: maximum at the last index, then at the first
    load_rand(-1000, 1000);
    mem_a[NA-1] = 16'd2000;
    scan_a("b2b_first", {8'(NA - 1), 16'd2000}, 0, 0);
    load_rand(-1000, 1000);
    mem_a[0] = 16'd3000;
    scan_a("b2b_second", {8'd0, 16'd3000}, 0, 0);

    repeat (3) tick();
    chk("a_sb_empty", 32'(exp_q_a.size()), 32'd0);
    chk("b_sb_empty", 32'(exp_q_b.size()), 32'd0);
    chk("a_done_count", 32'(done_cnt_a), 32'(exp_done_a));
    chk("b_done_count", 32'(done_cnt_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
